// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// FSM state encoding and a counter-width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with extra-MSB pointers; full/empty come from
// comparing the wrap bit and the address bits of the two pointers.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fed framer with configurable width,
// parity, stop bits and baud divisor. TxD is registered from the FSM state.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_BITS-1:0]              data,
  input  logic                              data_valid,
  output logic                              data_ready,
  output logic                              TxD,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam int BW  = cnt_width(BAUD_DIV);
  localparam int NBW = cnt_width(DATA_BITS);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [NBW-1:0] DATA_LAST = NBW'(DATA_BITS - 1);
  localparam logic [NBW-1:0] STOP_LAST = NBW'(STOP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [NBW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   ovf_q;

  logic                   push, pop, load, bit_end;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;

  assign data_ready = !reset && !fifo_full;
  assign push       = data_valid && data_ready;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  // NOTE: every always_comb output gets a default first, so no latches form.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;

    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE:  load = !fifo_empty;
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        bit_d   = '0;
      end
      ST_DATA:  if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == DATA_LAST) begin
          bit_d   = '0;
          state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_PAR:   if (bit_end) begin
        state_d = ST_STOP;
        bit_d   = '0;
      end
      ST_STOP:  if (bit_end) begin
        if (bit_q == STOP_LAST) begin
          bit_d   = '0;
          state_d = ST_IDLE;
          load    = !fifo_empty;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // Payload and its parity are captured at pop so later writes cannot disturb the frame.
    if (load) begin
      shift_d = fifo_rdata;
      par_d   = (PARITY == PAR_ODD) ? ~(^fifo_rdata) : ^fifo_rdata;
      baud_d  = '0;
      bit_d   = '0;
      state_d = ST_START;
    end
  end

  assign pop = load;

  always_comb begin
    case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      ST_PAR:   txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ovf_q   <= data_valid && !data_ready;
    end
  end

  assign TxD      = txd_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: five differently configured instances,
// directed pushes queue hand-computed frames, per-instance monitors compare TxD.
module tb_uart_tx_param;

  localparam int B = 4;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [8:0] d4 = '0;
  logic [4:0] v = '0;
  wire  [4:0] rdy, txd, busy, ovf;
  wire  [4:0] c0, c1, c2, c4;
  wire  [2:0] c3;

  uart_tx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .reset(reset), .data(d0), .data_valid(v[0]), .data_ready(rdy[0]),
    .TxD(txd[0]), .busy(busy[0]), .fifo_count(c0), .overflow(ovf[0]));
  uart_tx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .reset(reset), .data(d1), .data_valid(v[1]), .data_ready(rdy[1]),
    .TxD(txd[1]), .busy(busy[1]), .fifo_count(c1), .overflow(ovf[1]));
  uart_tx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .reset(reset), .data(d2), .data_valid(v[2]), .data_ready(rdy[2]),
    .TxD(txd[2]), .busy(busy[2]), .fifo_count(c2), .overflow(ovf[2]));
  uart_tx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .reset(reset), .data(d3), .data_valid(v[3]), .data_ready(rdy[3]),
    .TxD(txd[3]), .busy(busy[3]), .fifo_count(c3), .overflow(ovf[3]));
  uart_tx_param #(.BAUD_DIV(B), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u4 (
    .clk(clk), .reset(reset), .data(d4), .data_valid(v[4]), .data_ready(rdy[4]),
    .TxD(txd[4]), .busy(busy[4]), .fifo_count(c4), .overflow(ovf[4]));

  int     checks = 0;
  int     failures = 0;
  frame_t exp_q [5][$];
  int     start_q [5][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle of every bit must match, which also pins down bit duration.
  task automatic monitor(input int id);
    frame_t f;
    int     bad;
    bit     abort;
    forever begin
      @(negedge clk);
      if (reset || txd[id] !== 1'b0) continue;
      start_q[id].push_back(cyc);
      if (exp_q[id].size() == 0) begin
        check($sformatf("u%0d_unexpected_start", id), 1, 0);
        for (int k = 0; k < 64 && txd[id] === 1'b0; k++) @(negedge clk);
        continue;
      end
      f = exp_q[id].pop_front();
      abort = 1'b0;
      for (int b = 0; b < f.len && !abort; b++) begin
        bad = 0;
        for (int c = 0; c < B; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          if (txd[id] !== f.bits[b]) bad++;
        end
        if (!abort) check($sformatf("u%0d_bit%0d", id, b), bad, 0);
      end
    end
  endtask

  // Called at a negedge; offers one word for exactly one rising edge.
  task automatic send(input int id, input logic [8:0] dat, input logic [15:0] bits,
                      input int len, input bit expect_it, output int edge_no);
    frame_t f;
    case (id)
      0: d0 = dat[7:0];
      1: d1 = dat[7:0];
      2: d2 = dat[7:0];
      3: d3 = dat[7:0];
      default: d4 = dat;
    endcase
    v[id] = 1'b1;
    edge_no = cyc + 1;
    if (expect_it) begin
      f.bits = bits;
      f.len  = len;
      exp_q[id].push_back(f);
    end
    @(negedge clk);
    v[id] = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_start(input int id, input int exp_cyc, input string name);
    int s;
    s = -1;
    if (start_q[id].size() != 0) s = start_q[id].pop_front();
    check(name, s, exp_cyc);
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {7'b0, 1'b1, d, 1'b0};
  endfunction

  initial begin
    fork
      monitor(0); monitor(1); monitor(2); monitor(3); monitor(4);
    join_none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, ea, eb, ec, k, r, q;

    repeat (3) @(negedge clk);
    check("reset_txd", txd, 5'h1f);
    check("reset_busy", busy, 5'h00);
    check("reset_ready", rdy, 5'h00);
    check("reset_ovf", ovf, 5'h00);
    check("reset_count0", c0, 0);
    reset = 1'b0;
    #1 check("ready_after_release", rdy, 5'h1f);
    @(negedge clk);

    // Single 8N1 frame of 0xA5, latency and busy release
    send(0, 9'h0A5, 16'h034A, 10, 1'b1, e);
    check("single_busy_queued", busy[0], 1);
    check("single_count_queued", c0, 1);
    @(negedge clk);
    check("single_txd_e1", txd[0], 1);
    check("single_count_popped", c0, 0);
    @(negedge clk);
    check("single_txd_e2_start", txd[0], 0);
    wait_until(e + 40);
    check("single_busy_last", busy[0], 1);
    wait_until(e + 41);
    check("single_busy_done", busy[0], 0);
    wait_until(e + 42);
    check("single_txd_idle", txd[0], 1);
    check_start(0, e + 2, "single_start_cycle");

    // Parity: even 0x55 -> 0, odd 0x55 -> 1, odd 0x07 -> 0
    send(1, 9'h055, 16'b1_0_01010101_0, 11, 1'b1, e);
    send(2, 9'h055, 16'b1_1_01010101_0, 11, 1'b1, e2);
    send(2, 9'h007, 16'b1_0_00000111_0, 11, 1'b1, k);
    wait_until(e + 44);
    check("even_busy_last", busy[1], 1);
    wait_until(e + 45);
    check("even_busy_done", busy[1], 0);
    wait_until(e2 + 95);
    check_start(1, e + 2, "even_start");
    check_start(2, e2 + 2, "odd_a_start");
    check_start(2, e2 + 46, "odd_b_start_44clk");
    check("odd_busy_done", busy[2], 0);

    // Back-to-back frames, no idle gap between stop and next start
    send(0, 9'h001, f8n1(8'h01), 10, 1'b1, ea);
    send(0, 9'h002, f8n1(8'h02), 10, 1'b1, eb);
    send(0, 9'h003, f8n1(8'h03), 10, 1'b1, ec);
    check("b2b_count_after_push", c0, 2);
    wait_until(ea + 40);
    check("b2b_count_before_pop2", c0, 2);
    wait_until(ea + 41);
    check("b2b_count_after_pop2", c0, 1);
    wait_until(ea + 80);
    check("b2b_count_before_pop3", c0, 1);
    wait_until(ea + 81);
    check("b2b_count_after_pop3", c0, 0);
    wait_until(ea + 121);
    check("b2b_busy_done", busy[0], 0);
    check_start(0, ea + 2, "b2b_start1");
    check_start(0, ea + 42, "b2b_start2");
    check_start(0, ea + 82, "b2b_start3");

    // Depth-4 FIFO: five accepted (4 queued + 1 in flight), sixth dropped
    for (int i = 0; i < 6; i++) begin
      send(3, 9'(8'h10 + i), f8n1(8'(8'h10 + i)), 10, (i < 5), k);
      if (i == 0) e = k;
      check($sformatf("ovf_ready_%0d", i), rdy[3], (i < 4) ? 1 : 0);
      check($sformatf("ovf_pulse_%0d", i), ovf[3], (i == 5) ? 1 : 0);
    end
    check("ovf_count_full", c3, 4);
    @(negedge clk);
    check("ovf_pulse_end", ovf[3], 0);
    wait_until(e + 2 + 5 * 40 + 4);
    for (int j = 0; j < 5; j++) check_start(3, e + 2 + 40 * j, $sformatf("ovf_start%0d", j));
    check("ovf_busy_done", busy[3], 0);

    // 9 data bits, two stop bits: 12-bit frame
    send(4, 9'h1FF, 16'h0FFE, 12, 1'b1, e);
    wait_until(e + 48);
    check("nine_busy_last", busy[4], 1);
    wait_until(e + 49);
    check("nine_busy_done", busy[4], 0);
    check_start(4, e + 2, "nine_start");

    // Reset during a DATA bit, then a clean frame
    send(0, 9'h0AA, f8n1(8'hAA), 10, 1'b1, r);
    send(0, 9'h011, f8n1(8'h11), 10, 1'b1, k);
    send(0, 9'h022, f8n1(8'h22), 10, 1'b1, k);
    wait_until(r + 7);
    check("rst_pre_txd_low", txd[0], 0);
    #2 reset = 1'b1;
    #1;
    check("rst_txd_high", txd[0], 1);
    check("rst_count_zero", c0, 0);
    check("rst_busy_low", busy[0], 0);
    check("rst_ready_low", rdy[0], 0);
    exp_q[0].delete();
    start_q[0].delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_ready_release", rdy[0], 1);
    @(negedge clk);
    send(0, 9'h03C, f8n1(8'h3C), 10, 1'b1, q);
    wait_until(q + 45);
    check_start(0, q + 2, "rst_clean_start");
    check("rst_clean_busy_done", busy[0], 0);

    for (int i = 0; i < 5; i++)
      check($sformatf("u%0d_frames_outstanding", i), exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
